// File: rtl/operand_sequencer.sv
// operand_sequencer: holds one operand set (a, b, c) and sweeps selector s from 0 to smax.
// Optional macro SEQ_SMAX_CLAMP_EN limits the latched sweep limit to 7.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready operand-set handshake; in_ready high only in IDLE
//   in_a, in_b, in_c    operands loaded on accept
//   in_smax             inclusive last selector value of the sweep
//   abort               synchronous sweep cancel; wins over a beat and over an accept
//   a, b, c, s          registered operands and selector to the mux stage
//   out_valid/out_ready output beat handshake
//   done                one-cycle pulse after the final beat of a sweep
module operand_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_smax,
    input  logic             abort,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             done
);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] smax, smax_n, lim;
    logic [WIDTH-1:0] a_n, b_n, c_n, s_n;
    logic             done_n;
    logic             beat, last;

`ifdef SEQ_SMAX_CLAMP_EN
    // Selector values of 8 and above select nothing defined in the mux stage.
    assign lim = (in_smax > WIDTH'(7)) ? WIDTH'(7) : in_smax;
`else
    assign lim = in_smax;
`endif

    // Both handshake outputs depend on the state register only.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SWEEP);
    assign beat      = out_valid && out_ready;
    // Equality ends the sweep, so smax = all-ones never wraps s.
    assign last      = (s == smax);

    always_comb begin
        state_n = state;
        a_n     = a;
        b_n     = b;
        c_n     = c;
        s_n     = s;
        smax_n  = smax;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid && !abort) begin
                    a_n     = in_a;
                    b_n     = in_b;
                    c_n     = in_c;
                    s_n     = '0;
                    smax_n  = lim;
                    state_n = SWEEP;
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (beat) begin
                    if (last) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            c     <= '0;
            s     <= '0;
            smax  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            a     <= a_n;
            b     <= b_n;
            c     <= c_n;
            s     <= s_n;
            smax  <= smax_n;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer: directed stimulus with a beat scoreboard
// and a negedge monitor for operand_sequencer.
module tb_operand_sequencer;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [W-1:0] s;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b, in_c, in_smax;
    logic         abort;
    logic [W-1:0] a, b, c, s;
    logic         out_valid;
    logic         out_ready;
    logic         done;

    int    tests = 0;
    int    fails = 0;
    beat_t sbq[$];
    bit    exp_done = 1'b0;

    operand_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_smax(in_smax),
        .abort(abort),
        .a(a), .b(b), .c(c), .s(s),
        .out_valid(out_valid), .out_ready(out_ready),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sweep(input logic [W-1:0] pa, pb, pc,
                              input int first, input int lastv,
                              input bit has_end);
        beat_t e;
        for (int i = first; i <= lastv; i++) begin
            e.a = pa; e.b = pb; e.c = pc;
            e.s = W'(i);
            e.last = has_end && (i == lastv);
            sbq.push_back(e);
        end
    endtask

    task automatic offer(input logic [W-1:0] pa, pb, pc, sm);
        in_a = pa; in_b = pb; in_c = pc; in_smax = sm;
        in_valid = 1'b1;
    endtask

    // Monitor: scores every beat and checks done against the previous beat.
    always @(negedge clk) begin
        beat_t e;
        bit    nxt;
        nxt = 1'b0;
        if ((done || exp_done) === 1'b1)
            chk("done_pulse", {31'd0, done}, {31'd0, exp_done});
        if (out_valid === 1'b1 && out_ready === 1'b1 &&
            abort !== 1'b1 && rst_n === 1'b1) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL beat_unexpected: got s=%0d expected none", s);
            end else begin
                e = sbq.pop_front();
                chk("beat_abcs", {16'd0, a, b, c, s},
                    {16'd0, e.a, e.b, e.c, e.s});
                nxt = e.last;
            end
        end
        exp_done = nxt;
    end

    int rdy_pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    int s_pat   [7] = '{0, 1, 1, 1, 2, 3, 3};
    int lastv;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_c = '0; in_smax = '0;
        #3;
        chk("rst_abcs", {16'd0, a, b, c, s}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #10 rst_n = 1'b1;
        tick();

        // Sweep 0..5 with out_ready high.
        offer(3, 5, 9, 5);
        out_ready = 1'b1;
        push_sweep(3, 5, 9, 0, 5, 1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("t1_s", {28'd0, s}, i);
            chk("t1_in_ready_low", {31'd0, in_ready}, 32'd0);
            tick();
        end
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_done_idle", {30'd0, out_valid, in_ready}, 32'd1);
        tick();
        chk("t1_done_once", {31'd0, done}, 32'd0);

        // Stalled sweep 0..3.
        offer(2, 4, 6, 3);
        out_ready = 1'b0;
        push_sweep(2, 4, 6, 0, 3, 1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            out_ready = rdy_pat[i][0];
            chk("t2_s_hold", {28'd0, s}, s_pat[i]);
            tick();
        end
        chk("t2_done", {31'd0, done}, 32'd1);
        tick();

        // Full-range limit.
`ifdef SEQ_SMAX_CLAMP_EN
        lastv = 7;
`else
        lastv = 15;
`endif
        offer(1, 2, 3, 15);
        out_ready = 1'b1;
        push_sweep(1, 2, 3, 0, lastv, 1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i <= lastv; i++) tick();
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_last_s", {28'd0, s}, lastv);
        tick();

        // Abort on the s=2 beat.
        offer(1, 2, 4, 5);
        push_sweep(1, 2, 4, 0, 1, 0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("t4_s_before", {28'd0, s}, 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_idle", {30'd0, out_valid, in_ready}, 32'd1);
        chk("t4_s_hold", {28'd0, s}, 32'd2);
        chk("t4_no_done", {31'd0, done}, 32'd0);
        tick();
        chk("t4_no_done2", {31'd0, done}, 32'd0);
        offer(7, 7, 7, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        chk("t4_not_loaded", {30'd0, out_valid, in_ready}, 32'd1);
        chk("t4_a_kept", {28'd0, a}, 32'd1);
        tick();

        // Asynchronous reset at s=4.
        offer(6, 6, 6, 9);
        push_sweep(6, 6, 6, 0, 3, 0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t5_s4", {28'd0, s}, 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_abcs", {16'd0, a, b, c, s}, 32'd0);
        chk("t5_rst_flags", {29'd0, out_valid, done, in_ready}, 32'd1);
        sbq.delete();
        #1 rst_n = 1'b1;
        tick();
        offer(2, 3, 4, 1);
        push_sweep(2, 3, 4, 0, 1, 1);
        tick();
        in_valid = 1'b0;
        chk("t5_restart_s0", {27'd0, out_valid, s}, 32'h10);
        tick();
        tick();
        chk("t5_done", {31'd0, done}, 32'd1);
        tick();

        // Back-to-back sweeps with in_valid held.
        offer(1, 1, 1, 1);
        push_sweep(1, 1, 1, 0, 1, 1);
        push_sweep(8, 8, 8, 0, 2, 1);
        tick();
        offer(8, 8, 8, 2);
        tick();
        tick();
        chk("t6_done_accept", {30'd0, done, in_ready}, 32'd3);
        tick();
        in_valid = 1'b0;
        chk("t6_second_s0", {23'd0, out_valid, a, s}, 32'h180);
        for (int i = 0; i < 3; i++) tick();
        chk("t6_done2", {31'd0, done}, 32'd1);
        tick();

        chk("sb_empty", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Upstream feeder for the selector-driven output mux stage. Accepts one operand set (a, b, c) and a sweep limit through a valid/ready handshake, then holds a, b, c stable while stepping the selector s from 0 up to the limit, one value per accepted output beat. Downstream sees registered, glitch-free a/b/c/s plus a valid qualifier, and a one-cycle done pulse at the end of each sweep.

## Interface
- WIDTH, 4: width of a, b, c, s and of the sweep limit.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand set and limit present on in_a/in_b/in_c/in_smax.
- in_ready  output  1  block can accept an operand set; high only in IDLE.
- in_a, in_b, in_c  input  WIDTH each  operands to be held for the sweep.
- in_smax  input  WIDTH  last selector value of the sweep (inclusive).
- abort  input  1  synchronous sweep cancel.
- a, b, c  output  WIDTH each  registered operands to the mux stage.
- s  output  WIDTH  registered selector to the mux stage.
- out_valid  output  1  a/b/c/s form a valid beat.
- out_ready  input  1  downstream accepts the current beat.
- done  output  1  one-cycle pulse after the final beat of a sweep.

## Operation
- States: IDLE, SWEEP. in_ready = (state == IDLE), combinational from state only.
- IDLE: out_valid=0. On in_valid && in_ready: load a/b/c from in_a/in_b/in_c, latch smax (clamped per Configuration), s<=0, state<=SWEEP.
- SWEEP: out_valid=1; a, b, c, s held constant while out_ready=0.
- Beat = out_valid && out_ready at a rising edge. On a beat with s != smax: s<=s+1. On a beat with s == smax: state<=IDLE, done<=1 for the next cycle, s held.
- Sweep end detected by equality compare, never by counter overflow; smax = 2^WIDTH-1 produces 2^WIDTH beats with no wrap of s to 0 inside the sweep.
- abort (any state): state<=IDLE next edge, done stays 0, a/b/c/s hold last values. abort has priority over a simultaneous beat and over a simultaneous accept in IDLE (the set is not loaded).
- Beats per sweep = smax+1. done is asserted only from the final beat, never from abort or reset.

## Timing
- Reset values: a=b=c=s=0, out_valid=0, done=0, state=IDLE (hence in_ready=1), smax=0. Applied immediately on rst_n low, including mid-sweep; sweep is lost.
- Accept at edge N -> out_valid=1 with s=0 from edge N (visible in cycle N+1).
- One beat per cycle maximum; with out_ready held high, s steps 0..smax on consecutive cycles.
- done high exactly one cycle, coincident with out_valid=0 and in_ready=1; a new set may be accepted in that same cycle, giving s=0 the following cycle (one-cycle bubble between sweeps).
- No combinational path from in_valid or out_ready to any output.

## Configuration
- SEQ_SMAX_CLAMP_EN defined: latched smax = min(in_smax, 7); the mux stage never receives s >= 8 (its undefined-output region).
- Not defined: latched smax = in_smax unmodified, full 0..2^WIDTH-1 sweep.

## Test plan
- Reset then in_a=3, in_b=5, in_c=9, in_smax=5, out_ready=1 -> s=0,1,2,3,4,5 on six consecutive cycles, a/b/c stay 3/5/9, done one cycle after s=5 beat, in_ready low throughout SWEEP.
- in_smax=3, out_ready toggled 1,0,0,1,1,0,1 -> s advances only on ready cycles, sequence 0,1,2,3, values held during stalls, exactly 4 beats then done.
- in_smax=15: without macro -> 16 beats, s=15 last, no wrap to 0; with SEQ_SMAX_CLAMP_EN -> 8 beats, s=7 last.
- abort asserted on s=2 beat with out_ready=1 -> next cycle IDLE, out_valid=0, done=0, s holds 2; abort with in_valid in IDLE -> set not loaded.
- rst_n pulled low mid-sweep at s=4 (async, between edges) -> all outputs 0, in_ready=1 immediately; new set after release starts at s=0.
- Back-to-back: in_valid held high with second set ready -> second set accepted in done cycle, s=0 of second sweep on the next cycle.
